// File: rtl/ifid_buf_if.sv
`default_nettype none
// ============================================================================
// Module      : ifid_buf_if
// Description : Bundle of signals between fetch, the IF/ID buffer and decode.
//               Fetch side : in_valid, in_ready, ins, pc_in, immode, flush
//               Decode side: out_valid, out_ready, rdn, rs1n, rs2n, imm, pc,
//                            count
//               slave  : view taken by the buffer itself
//               master : view taken by the surrounding pipeline / bench
// Revision    : 1.0 - initial release
// ============================================================================
interface ifid_buf_if #(
    parameter int WordSize = 32,
    parameter int Depth    = 2
);
    logic                       in_valid;
    logic                       in_ready;
    logic [31:0]                ins;
    logic [WordSize-1:0]        pc_in;
    logic [2:0]                 immode;
    logic                       flush;
    logic                       out_valid;
    logic                       out_ready;
    logic [4:0]                 rdn;
    logic [4:0]                 rs1n;
    logic [4:0]                 rs2n;
    logic [WordSize-1:0]        imm;
    logic [WordSize-1:0]        pc;
    logic [$clog2(Depth):0]     count;

    modport slave (
        input  in_valid, ins, pc_in, immode, flush, out_ready,
        output in_ready, out_valid, rdn, rs1n, rs2n, imm, pc, count
    );

    modport master (
        output in_valid, ins, pc_in, immode, flush, out_ready,
        input  in_ready, out_valid, rdn, rs1n, rs2n, imm, pc, count
    );
endinterface
`default_nettype wire

// File: rtl/ifid_buf.sv
`default_nettype none
// ============================================================================
// Module      : ifid_buf
// Description : IF/ID pipeline buffer. Decodes register fields and the
//               immediate when an instruction is accepted and stores the
//               decoded entry in a small FIFO read by the decode stage.
// Ports       : clk  - clock, all state on rising edge
//               rstn - asynchronous active-low reset
//               bus  - ifid_buf_if.slave (fetch handshake, flush, decoded
//                      head entry, occupancy count)
// Revision    : 1.0 - initial release
// ============================================================================
module ifid_buf #(
    parameter int WordSize = 32,
    parameter int Depth    = 2
) (
    input  wire logic   clk,
    input  wire logic   rstn,
    ifid_buf_if.slave   bus
);
    localparam int                 c_PTR_W = $clog2(Depth);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(Depth);

    logic [c_PTR_W-1:0]  r_wptr;
    logic [c_PTR_W-1:0]  r_rptr;
    logic [c_CNT_W-1:0]  r_count;

    logic [4:0]          r_rd_mem  [Depth];
    logic [4:0]          r_rs1_mem [Depth];
    logic [4:0]          r_rs2_mem [Depth];
    logic [WordSize-1:0] r_imm_mem [Depth];
    logic [WordSize-1:0] r_pc_mem  [Depth];

    logic                w_in_ready;
    logic                w_out_valid;
    logic                w_push;
    logic                w_pop;
    logic [31:0]         w_imm32;
    logic [WordSize-1:0] w_imm_ext;

    // Handshake flags depend only on registered occupancy, so there is no
    // combinational path from out_ready to in_ready.
    assign w_in_ready  = (r_count < c_FULL);
    assign w_out_valid = (r_count != '0);
    assign w_push      = bus.in_valid && w_in_ready  && !bus.flush;
    assign w_pop       = w_out_valid  && bus.out_ready && !bus.flush;

    // Immediate assembled as a 32-bit value already sign-extended from
    // ins[31]; widened below for 64-bit configurations.
    always_comb begin
        w_imm32 = '0;
        case (bus.immode)
            3'd1:       w_imm32 = {{20{bus.ins[31]}}, bus.ins[31:20]};
            3'd2, 3'd3: w_imm32 = {{20{bus.ins[31]}}, bus.ins[31:25], bus.ins[11:7]};
            3'd4:       w_imm32 = {{19{bus.ins[31]}}, bus.ins[31], bus.ins[7],
                                   bus.ins[30:25], bus.ins[11:8], 1'b0};
            3'd5:       w_imm32 = {bus.ins[31:12], 12'b0};
            3'd6:       w_imm32 = {{11{bus.ins[31]}}, bus.ins[31], bus.ins[19:12],
                                   bus.ins[20], bus.ins[30:21], 1'b0};
            default:    w_imm32 = '0;
        endcase
    end

    generate
        if (WordSize > 32) begin : g_imm_wide
            assign w_imm_ext = {{(WordSize-32){w_imm32[31]}}, w_imm32};
        end else begin : g_imm_native
            assign w_imm_ext = w_imm32;
        end
    endgenerate

    // Storage needs no reset: every read is masked by out_valid, which is
    // driven from the (reset) occupancy count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd_mem[r_wptr]  <= bus.ins[11:7];
            r_rs1_mem[r_wptr] <= bus.ins[19:15];
            r_rs2_mem[r_wptr] <= bus.ins[24:20];
            r_imm_mem[r_wptr] <= w_imm_ext;
            r_pc_mem[r_wptr]  <= bus.pc_in;
        end
    end

    // Pointers wrap naturally because Depth is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (bus.flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.count     = r_count;
    assign bus.rdn       = w_out_valid ? r_rd_mem[r_rptr]  : '0;
    assign bus.rs1n      = w_out_valid ? r_rs1_mem[r_rptr] : '0;
    assign bus.rs2n      = w_out_valid ? r_rs2_mem[r_rptr] : '0;
    assign bus.imm       = w_out_valid ? r_imm_mem[r_rptr] : '0;
    assign bus.pc        = w_out_valid ? r_pc_mem[r_rptr]  : '0;
endmodule
`default_nettype wire

// File: tb/tb_ifid_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifid_buf
// Description : Self-checking bench for ifid_buf (WordSize=32, Depth=2).
//               Accepted pushes place their expected decoded entry in a
//               queue; the head outputs are compared to the queue front.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifid_buf;
    localparam int c_WS    = 32;
    localparam int c_DEPTH = 2;

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] pc;
    } ent_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    ifid_buf_if #(.WordSize(c_WS), .Depth(c_DEPTH)) bus ();

    ifid_buf #(.WordSize(c_WS), .Depth(c_DEPTH)) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    ent_t q[$];
    ent_t e_next;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        ent_t h;
        h = '0;
        if (q.size() != 0) h = q[0];
        check("count",     64'(bus.count), 64'(q.size()));
        check("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
        check("in_ready",  64'(bus.in_ready), 64'(q.size() < c_DEPTH));
        check("head_rdn",  64'(bus.rdn),  64'(h.rd));
        check("head_rs1n", 64'(bus.rs1n), 64'(h.rs1));
        check("head_rs2n", 64'(bus.rs2n), 64'(h.rs2));
        check("head_imm",  64'(bus.imm),  64'(h.imm));
        check("head_pc",   64'(bus.pc),   64'(h.pc));
    endtask

    // Checks the current outputs, then advances one clock and updates the
    // scoreboard according to what the buffer should have done.
    task automatic cycle();
        bit   acc;
        bit   pop;
        ent_t e;
        check_outputs();
        acc = bus.in_valid && (q.size() < c_DEPTH) && !bus.flush;
        pop = (q.size() != 0) && bus.out_ready && !bus.flush;
        e   = e_next;
        @(posedge clk);
        #1;
        if (bus.flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [2:0] mode, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm);
        bus.in_valid = v;
        bus.ins      = ins;
        bus.pc_in    = pc;
        bus.immode   = mode;
        e_next       = '{rd: rd, rs1: rs1, rs2: rs2, imm: imm, pc: pc};
    endtask

    // I-type instruction built from its fields; expected values follow
    // directly from the chosen fields.
    task automatic push_i(input logic [11:0] im, input logic [4:0] rs1,
                          input logic [4:0] rd, input logic [31:0] pc);
        drive(1'b1, {im, rs1, 3'b000, rd, 7'h13}, pc, 3'd1, rd, rs1, im[4:0],
              {{20{im[11]}}, im});
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.ins       = '0;
        bus.pc_in     = '0;
        bus.immode    = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        e_next        = '0;

        // Reset state
        #12;
        check_outputs();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        check("post_reset_in_ready", 64'(bus.in_ready), 64'd1);

        // Basic I-type push, first edge after reset release
        drive(1'b1, 32'h00500093, 32'h100, 3'd1, 5'd1, 5'd0, 5'd5, 32'h5);
        cycle();
        idle();
        check("i_imm", 64'(bus.imm), 64'h5);
        check("i_pc",  64'(bus.pc),  64'h100);
        cycle();
        bus.out_ready = 1'b1;
        cycle();
        cycle();

        // B, U, J immediates with concurrent push/pop
        drive(1'b1, 32'hFE000EE3, 32'h200, 3'd4, 5'd29, 5'd0, 5'd0, 32'hFFFFFFFC);
        cycle();
        drive(1'b1, 32'h123450B7, 32'h204, 3'd5, 5'd1, 5'd8, 5'd3, 32'h12345000);
        cycle();
        drive(1'b1, 32'hFF9FF06F, 32'h208, 3'd6, 5'd0, 5'd31, 5'd25, 32'hFFFFFFF8);
        cycle();
        idle();
        cycle();
        cycle();

        // S-type, then immode 7 and immode 0 yield a zero immediate
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h00112423, 32'h300, 3'd2, 5'd8, 5'd2, 5'd1, 32'h8);
        cycle();
        drive(1'b1, 32'hFFFFFFFF, 32'h304, 3'd7, 5'd31, 5'd31, 5'd31, 32'h0);
        cycle();
        idle();
        bus.out_ready = 1'b1;
        cycle();
        drive(1'b1, 32'hFFFFFFFF, 32'h308, 3'd0, 5'd31, 5'd31, 5'd31, 32'h0);
        cycle();
        idle();
        cycle();
        cycle();

        // Full buffer: third push must be refused, then drain in order
        bus.out_ready = 1'b0;
        push_i(12'h0A1, 5'd3, 5'd4, 32'h400);
        cycle();
        push_i(12'h8B2, 5'd5, 5'd6, 32'h404);
        cycle();
        check("full_in_ready", 64'(bus.in_ready), 64'd0);
        check("full_count",    64'(bus.count),    64'd2);
        push_i(12'h7C3, 5'd7, 5'd8, 32'h408);
        cycle();
        cycle();
        idle();
        bus.out_ready = 1'b1;
        cycle();
        cycle();
        cycle();

        // Simultaneous push/pop at count=1 across pointer wrap
        bus.out_ready = 1'b0;
        push_i(12'h010, 5'd9, 5'd10, 32'h500);
        cycle();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2 * c_DEPTH; i++) begin
            push_i(i[0] ? (12'hF00 + 12'(i)) : (12'h020 + 12'(i)),
                   5'(i + 2), 5'(i + 1), 32'h504 + 32'(4 * i));
            cycle();
            check("wrap_count", 64'(bus.count), 64'd1);
        end
        idle();
        cycle();
        cycle();

        // Flush with count=2 and an incoming push
        bus.out_ready = 1'b0;
        push_i(12'h111, 5'd1, 5'd2, 32'h600);
        cycle();
        push_i(12'h222, 5'd3, 5'd4, 32'h604);
        cycle();
        push_i(12'h333, 5'd5, 5'd6, 32'h608);
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        idle();
        check("flush2_count", 64'(bus.count), 64'd0);
        cycle();

        // Flush with count=1 while in_ready=1: incoming entry still dropped
        push_i(12'h444, 5'd7, 5'd8, 32'h700);
        cycle();
        push_i(12'h555, 5'd9, 5'd10, 32'h704);
        bus.flush = 1'b1;
        bus.out_ready = 1'b1;
        cycle();
        bus.flush = 1'b0;
        idle();
        cycle();

        // Asynchronous reset between edges with count=2
        bus.out_ready = 1'b0;
        push_i(12'h666, 5'd11, 5'd12, 32'h800);
        cycle();
        push_i(12'h777, 5'd13, 5'd14, 32'h804);
        cycle();
        idle();
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        check("rst_count",     64'(bus.count),     64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_rdn",       64'(bus.rdn),       64'd0);
        check("rst_imm",       64'(bus.imm),       64'd0);
        check("rst_pc",        64'(bus.pc),        64'd0);
        q.delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        push_i(12'h888, 5'd15, 5'd16, 32'h900);
        cycle();
        idle();
        bus.out_ready = 1'b1;
        cycle();
        cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ifid_buf.md
IFID_BUF -- requirements
Module: ifid_buf

Interface
- REQ-001 SHALL have parameter WordSize, default 32: width of pc_in, pc and imm; legal values are 32 and 64.
- REQ-002 SHALL have parameter Depth, default 2: number of buffered IF/ID entries; legal values are powers of two ≥ 2.
- REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
- REQ-004 SHALL have port rstn, input, 1 bit: reset, asynchronous assert, active-low.
- REQ-005 SHALL have port in_valid, input, 1 bit: fetch stage presents an instruction.
- REQ-006 SHALL have port in_ready, output, 1 bit: buffer accepts the instruction this cycle.
- REQ-007 SHALL have port ins, input, 32 bits: instruction word.
- REQ-008 SHALL have port pc_in, input, WordSize bits: instruction address.
- REQ-009 SHALL have port immode, input, 3 bits: immediate format selector.
- REQ-010 SHALL have port flush, input, 1 bit: discard all buffered and incoming entries.
- REQ-011 SHALL have port out_valid, output, 1 bit: head entry is valid.
- REQ-012 SHALL have port out_ready, input, 1 bit: decode stage consumes the head entry.
- REQ-013 SHALL have port rdn, output, 5 bits: head entry destination register.
- REQ-014 SHALL have port rs1n, output, 5 bits: head entry source register 1.
- REQ-015 SHALL have port rs2n, output, 5 bits: head entry source register 2.
- REQ-016 SHALL have port imm, output, WordSize bits: head entry immediate.
- REQ-017 SHALL have port pc, output, WordSize bits: head entry address.
- REQ-018 SHALL have port count, output, $clog2(Depth)+1 bits: number of occupied entries.

Function
- REQ-019 SHALL complete a push when in_valid && in_ready && !flush, and a pop when out_valid && out_ready && !flush.
- REQ-020 SHALL drive in_ready = (count < Depth), with no combinational path from out_ready.
- REQ-021 SHALL drive out_valid = (count != 0); an entry pushed at edge N is visible at the outputs after edge N (1-cycle latency).
- REQ-022 SHALL decode fields at push time as rdn=ins[11:7], rs1n=ins[19:15], rs2n=ins[24:20], and store the decoded values.
- REQ-023 SHALL form imm at push time, sign-extended from ins[31] to WordSize, as follows:
  - immode 1 (I): ins[31:20]
  - immode 2 and 3 (S): {ins[31:25], ins[11:7]}
  - immode 4 (B): {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}
  - immode 5 (U): {ins[31:12], 12'b0}
  - immode 6 (J): {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}
  - immode 0 and 7: imm = 0
- REQ-024 SHALL operate the storage in FIFO order using wrapping read/write pointers modulo Depth; count SHALL increment on push-only, decrement on pop-only, and hold on push+pop.
- REQ-025 SHALL permit simultaneous push and pop when 0 < count < Depth; when count == Depth only a pop SHALL occur (in_ready = 0); when count == 0 only a push SHALL occur.
- REQ-026 SHALL drive rdn, rs1n, rs2n, imm and pc to 0 whenever out_valid = 0.
- REQ-027 SHALL, when flush = 1, clear count and both pointers at the next edge and ignore that cycle's push and pop; flush SHALL take priority over all other events.
- REQ-028 SHALL hold head outputs stable while out_valid && !out_ready && !flush.

Reset
- REQ-029 SHALL, on rstn low, immediately set count=0, pointers=0, out_valid=0, and all data outputs to 0, independent of clk.
- REQ-030 SHALL drive in_ready = 1 after reset is released; the first push SHALL be possible at the first edge with rstn high.
- REQ-031 SHALL discard any entries in flight on reset asserted mid-operation; no partial entry SHALL survive.

Verification
- REQ-032 Push ins=0x00500093, pc_in=0x100, immode=1, out_ready=0 -> next cycle out_valid=1, rdn=1, rs1n=0, rs2n=5, imm=0x00000005, pc=0x100, count=1.
- REQ-033 Push 0xFE000EE3 with immode=4, then 0x123450B7 with immode=5, then 0xFF9FF06F with immode=6 -> heads popped in order with imm=0xFFFFFFFC, 0x12345000, 0xFFFFFFF8.
- REQ-034 With Depth=2 and out_ready=0, push 3 entries -> count=2 and in_ready=0 after the 2nd push; the 3rd entry is not accepted; raise out_ready -> entries popped in order A, B.
- REQ-035 With count=1, push and pop in the same cycle -> count stays 1 and the new entry becomes head; repeat 2·Depth times to exercise pointer wrap-around.
- REQ-036 With count=2, assert flush together with in_valid=1 -> next cycle count=0, out_valid=0, outputs 0, and the incoming entry is dropped.
- REQ-037 Assert rstn low between clock edges with count=2 -> count=0 and out_valid=0 immediately; after release in_ready=1.
